mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM: sequences IF/ID/EX/MEM/WB and decodes
// OpCode/Funct into combinational datapath strobes and selects.
//
// state | meaning
// IF    | fetch instruction, PC <= PC + 4
// ID    | decode, branch target into ALUOut, jumps complete here
// EX    | address calc / ALU op / beq compare
// MEM   | data memory access for lw/sw
// WB    | register file write-back
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [2:0] State
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;

  logic [2:0] state_q, state_d;

  logic is_r, is_jr, is_jalr, r_shift, r_arith;
  logic is_j, is_jal, is_beq, is_lw, is_sw, is_mem, i_arith;

  assign is_r    = (OpCode == OP_RTYPE);
  assign is_jr   = is_r && (Funct == FN_JR);
  assign is_jalr = is_r && (Funct == FN_JALR);
  assign r_shift = is_r && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
  assign r_arith = r_shift
                || (is_r && (Funct >= 6'h20) && (Funct <= 6'h27))
                || (is_r && ((Funct == FN_SLT) || (Funct == FN_SLTU)));
  assign is_j    = (OpCode == OP_J);
  assign is_jal  = (OpCode == OP_JAL);
  assign is_beq  = (OpCode == OP_BEQ);
  assign is_lw   = (OpCode == OP_LW);
  assign is_sw   = (OpCode == OP_SW);
  assign is_mem  = is_lw || is_sw;
  assign i_arith = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_SLTI)
                || (OpCode == OP_SLTIU) || (OpCode == OP_ANDI) || (OpCode == OP_ORI)
                || (OpCode == OP_LUI);

  always_comb begin
    state_d     = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = ALU_ADD;
    PCSource    = 2'd0;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        ALUSrcB = 2'd3;
        ExtOp   = 1'b1;
        if (is_j || is_jal) begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
          if (is_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end else if (is_jr || is_jalr) begin
          PCWrite  = 1'b1;
          PCSource = 2'd3;
          if (is_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd2;
          end
        end else if (r_arith || i_arith || is_mem || is_beq) begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (is_mem) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ExtOp   = 1'b1;
          state_d = S_MEM;
        end else if (r_arith) begin
          ALUSrcA = r_shift ? 2'd2 : 2'd1;
          ALUOp   = ALU_FUNCT;
          state_d = S_WB;
        end else if (i_arith) begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ExtOp   = !((OpCode == OP_ANDI) || (OpCode == OP_ORI));
          LuiOp   = (OpCode == OP_LUI);
          case (OpCode)
            OP_ANDI:  ALUOp = ALU_AND;
            OP_ORI:   ALUOp = ALU_OR;
            OP_SLTI:  ALUOp = ALU_SLT;
            OP_SLTIU: ALUOp = ALU_SLTU;
            default:  ALUOp = ALU_ADD;
          endcase
          state_d = S_WB;
        end else if (is_beq) begin
          ALUSrcA     = 2'd1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
        end
      end

      S_MEM: begin
        if (is_lw) begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = S_WB;
        end else if (is_sw) begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
      end

      S_WB: begin
        if (is_lw) begin
          RegWrite = 1'b1;
          MemtoReg = 2'd1;
        end else if (r_arith) begin
          RegWrite = 1'b1;
          RegDst   = 2'd1;
        end else if (i_arith) begin
          RegWrite = 1'b1;
        end
      end

      default: state_d = S_IF;
    endcase

    // Reset aborts the instruction outright: nothing may reach memory or the PC.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      RegDst      = 2'd0;
      MemtoReg    = 2'd0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ALUOp       = ALU_ADD;
      PCSource    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: instructions are classified
// and expected per-cycle control words are derived from a class/step table.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [2:0] ALUOp, State;

  int vectors     = 0;
  int miscompares = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp),
    .LuiOp(LuiOp), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, State};

  localparam int C_NOP = 0, C_JUMP = 1, C_BEQ = 2, C_SW = 3, C_RAR = 4, C_IAR = 5, C_LW = 6;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08 || fn == 6'h09) return C_JUMP;
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || (fn >= 6'h20 && fn <= 6'h27) ||
          fn == 6'h2a || fn == 6'h2b) return C_RAR;
      return C_NOP;
    end
    case (op)
      6'h02, 6'h03: return C_JUMP;
      6'h04: return C_BEQ;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f: return C_IAR;
      default: return C_NOP;
    endcase
  endfunction

  function automatic int n_steps(input int cls);
    case (cls)
      C_NOP, C_JUMP: return 2;
      C_BEQ:         return 3;
      C_SW:          return 4;
      C_LW:          return 5;
      default:       return 4;
    endcase
  endfunction

  // Phase sequence per class: arithmetic skips MEM, loads/stores visit it.
  function automatic logic [2:0] step_state(input int cls, input int step);
    if (step <= 2) return 3'(step);
    if (step == 3 && (cls == C_LW || cls == C_SW)) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [24:0] expect_vec(input int cls, input logic [5:0] op,
                                             input logic [5:0] fn, input int step);
    logic pcw, pcwc, iord, mr, mw, irw, rw, ext, lui;
    logic [1:0] rd, mtr, sa, sb, pcs;
    logic [2:0] alu, st;
    {pcw, pcwc, iord, mr, mw, irw, rw, ext, lui} = '0;
    {rd, mtr, sa, sb, pcs} = '0;
    alu = 3'd0;
    st  = step_state(cls, step);
    case (st)
      3'd0: begin mr = 1; irw = 1; sb = 2'd1; pcw = 1; end
      3'd1: begin
        sb = 2'd3; ext = 1;
        if (op == 6'h02 || op == 6'h03) begin
          pcw = 1; pcs = 2'd2;
          if (op == 6'h03) begin rw = 1; rd = 2'd2; mtr = 2'd2; end
        end
        if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
          pcw = 1; pcs = 2'd3;
          if (fn == 6'h09) begin rw = 1; rd = 2'd1; mtr = 2'd2; end
        end
      end
      3'd2: begin
        if (cls == C_LW || cls == C_SW) begin sa = 2'd1; sb = 2'd2; ext = 1; end
        if (cls == C_RAR) begin
          sa  = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
          alu = 3'd2;
        end
        if (cls == C_IAR) begin
          sa  = 2'd1; sb = 2'd2;
          ext = !(op == 6'h0c || op == 6'h0d);
          lui = (op == 6'h0f);
          alu = (op == 6'h0c) ? 3'd3 : (op == 6'h0d) ? 3'd4 :
                (op == 6'h0a) ? 3'd5 : (op == 6'h0b) ? 3'd6 : 3'd0;
        end
        if (cls == C_BEQ) begin sa = 2'd1; alu = 3'd1; pcwc = 1; pcs = 2'd1; end
      end
      3'd3: begin iord = 1; if (cls == C_LW) mr = 1; else mw = 1; end
      default: begin
        rw = 1;
        if (cls == C_LW)  mtr = 2'd1;
        if (cls == C_RAR) rd = 2'd1;
      end
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, rw, ext, lui, rd, mtr, sa, sb, alu, pcs, st};
  endfunction

  task automatic check(input string tag, input logic [24:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered in the IF cycle (just after an edge); leaves in the next IF cycle.
  // abort_at >= 0 asserts reset on the edge following that step.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    int cls, n, last;
    logic [24:0] zero;
    zero = '0;
    cls  = classify(op, fn);
    n    = n_steps(cls);
    last = (abort_at >= 0 && abort_at < n - 1) ? abort_at : n - 1;
    for (int s = 0; s <= last; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      if (s == 0) begin OpCode = 6'($urandom); Funct = 6'($urandom); end
      else        begin OpCode = op; Funct = fn; end
      #1;
      check($sformatf("op%02h_fn%02h_step%0d", op, fn, s), expect_vec(cls, op, fn, s));
    end
    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      check($sformatf("abort_op%02h_step%0d", op, last), zero);
      reset = 1'b0;
      #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] op_pool [20] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a,
                               6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h05, 6'h01,
                               6'h23, 6'h2b};
  logic [5:0] fn_pool [12] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h24, 6'h27,
                               6'h2a, 6'h2b, 6'h1f};

  initial begin
    logic [24:0] zero;
    logic [5:0]  op, fn;
    int          ab;
    zero   = '0;
    reset  = 1'b1;
    OpCode = 6'h00;
    Funct  = 6'h00;
    @(posedge clk); #1;
    check("reset_cycle1", zero);
    OpCode = 6'h23;
    @(posedge clk); #1;
    check("reset_cycle2", zero);
    reset = 1'b0;
    #1;

    run_instr(6'h23, 6'h00, -1);   // lw
    run_instr(6'h00, 6'h02, -1);   // srl
    run_instr(6'h04, 6'h11, -1);   // beq
    run_instr(6'h03, 6'h00, -1);   // jal
    run_instr(6'h3f, 6'h00, -1);   // unsupported -> NOP
    run_instr(6'h0d, 6'h00, -1);   // ori
    run_instr(6'h00, 6'h09, -1);   // jalr
    run_instr(6'h00, 6'h15, -1);   // unsupported funct
    run_instr(6'h2b, 6'h00, -1);   // sw
    run_instr(6'h0f, 6'h00, -1);   // lui
    run_instr(6'h23, 6'h00, 3);    // lw aborted in MEM
    run_instr(6'h23, 6'h00, -1);

    for (int i = 0; i < 300; i++) begin
      op = op_pool[$urandom_range(0, 19)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 11)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
